// File: rtl/e1_rate_meas.sv
// E1-vs-USB frequency error meter: counts E1 ticks per SOF period, sums the
// per-frame error against NOMINAL over a window of SOF frames and hands it out.
module e1_rate_meas #(
  parameter int W        = 16,
  parameter int NOMINAL  = 2048,
  parameter int WIN_LOG2 = 3,
  parameter int TIMEOUT  = 46080
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        tick_e1,
  input  logic        tick_sof,
  output logic [15:0] meas_err,
  output logic        meas_valid,
  input  logic        meas_ack,
  output logic        meas_ovr,
  output logic        sof_lost
);

  localparam int                  TW       = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0]        CNT_MAX  = '1;
  localparam logic [W-1:0]        NOM      = W'(NOMINAL);
  localparam logic [WIN_LOG2-1:0] WIN_LAST = '1;
  localparam logic [TW-1:0]       T_LAST   = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0]       T_SAT    = TW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, SYNC, RUN} state_t;

  state_t              state, state_next;
  logic [W-1:0]        cnt;
  logic [15:0]         acc;
  logic [WIN_LOG2-1:0] idx;
  logic [TW-1:0]       timer;

  logic signed [W:0]   delta;
  logic signed [31:0]  sum;
  logic [15:0]         sum_sat;
  logic                expire, sof_run, win_close;

  // Watchdog fires on the step into TIMEOUT; a SOF in that cycle wins.
  assign expire    = (state != IDLE) && !tick_sof && (timer == T_LAST);
  assign sof_run   = (state == RUN) && tick_sof;
  assign win_close = sof_run && (idx == WIN_LAST);

  always_comb begin
    // NOTE: every always_comb output is assigned up front so no path can infer a latch.
    delta   = $signed({1'b0, cnt}) - $signed({1'b0, NOM});
    sum     = {{16{acc[15]}}, acc} + {{(31-W){delta[W]}}, delta};
    sum_sat = sum[15:0];
    if (sum > 32'sd32767)       sum_sat = 16'h7fff;
    else if (sum < -32'sd32768) sum_sat = 16'h8000;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (enable)   state_next = SYNC;
      SYNC:    if (tick_sof) state_next = RUN;
      RUN:     if (expire)   state_next = SYNC;
      default:               state_next = IDLE;
    endcase
    if (!enable) state_next = IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      acc        <= '0;
      idx        <= '0;
      timer      <= '0;
      meas_err   <= '0;
      meas_valid <= 1'b0;
      meas_ovr   <= 1'b0;
      sof_lost   <= 1'b0;
    end else if (!enable || state == IDLE) begin
      // Disabled: drop any partial window; the last result value is kept.
      cnt        <= '0;
      acc        <= '0;
      idx        <= '0;
      timer      <= '0;
      meas_valid <= 1'b0;
      meas_ovr   <= 1'b0;
      sof_lost   <= 1'b0;
    end else begin
      if (tick_sof)            timer <= '0;
      else if (timer != T_SAT) timer <= timer + TW'(1);

      // A tick coincident with SOF opens the new period.
      if (expire)                          cnt <= '0;
      else if (tick_sof)                   cnt <= {{(W-1){1'b0}}, tick_e1};
      else if (tick_e1 && cnt != CNT_MAX)  cnt <= cnt + W'(1);

      if (expire) begin
        acc      <= '0;
        idx      <= '0;
        sof_lost <= 1'b1;
      end else if (sof_run) begin
        acc <= win_close ? 16'h0000 : sum_sat;
        idx <= idx + WIN_LOG2'(1);
      end
      if (tick_sof) sof_lost <= 1'b0;

      if (win_close) begin
        meas_err   <= sum_sat;
        meas_valid <= 1'b1;
        meas_ovr   <= meas_valid && !meas_ack;
      end else if (meas_valid && meas_ack) begin
        meas_valid <= 1'b0;
        meas_ovr   <= 1'b0;
      end
    end
  end

endmodule
